// File: rtl/vproc_pkg.sv
// Shared types and sizing for the vector load/store path.
package vproc_pkg;

  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned LANES     = 16;
  localparam int unsigned DATA_W    = LANES * 32;
  localparam int unsigned MAX_BEATS = 32;
  localparam int unsigned BEAT_W    = $clog2(MAX_BEATS) + 1;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    LDRAIN = 2'd2,
    STORE  = 2'd3
  } state_t;

endpackage

// File: rtl/vector_lsu_agen.sv
// Address generator: current word address, stride, beats remaining, last-beat flag.
// VECTOR_LSU_STRIDE_EN adds a per-command stride; otherwise stride is LANES.
module vector_lsu_agen
  import vproc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [BEAT_W-1:0] beats,
`ifdef VECTOR_LSU_STRIDE_EN
  input  logic [ADDR_W-1:0] stride_in,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [BEAT_W-1:0] left;
  logic [ADDR_W-1:0] stride;

`ifdef VECTOR_LSU_STRIDE_EN
  // Stride captured with the command; zero repeats the same address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     stride <= ADDR_W'(LANES);
    else if (load) stride <= stride_in;
  end
`else
  assign stride = ADDR_W'(LANES);
`endif

  // Address and remaining-beat counters; address wraps modulo the memory depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= '0;
      left <= '0;
      last <= 1'b0;
    end else if (load) begin
      addr <= base;
      left <= beats;
      last <= (beats == BEAT_W'(1));
    end else if (step) begin
      addr <= addr + stride;
      left <= left - BEAT_W'(1);
      last <= (left == BEAT_W'(2));
    end
  end

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store sequencer in front of the 512x32 vector data memory.
// Optional per-command stride via VECTOR_LSU_STRIDE_EN.
module vector_lsu
  import vproc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [BEAT_W-1:0] cmd_beats,
`ifdef VECTOR_LSU_STRIDE_EN
  input  logic [ADDR_W-1:0] cmd_stride,
`endif
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [DATA_W-1:0] st_data,
  output logic              ld_valid,
  input  logic              ld_ready,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_last,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done
);

  state_t            state, state_nxt;
  logic              accept, capture, st_beat, drain;
  logic              agen_last;
  logic [ADDR_W-1:0] cur_addr;

  assign accept    = cmd_valid && (state == IDLE);
  assign capture   = (state == LOAD) && (!ld_valid || ld_ready);
  assign st_beat   = (state == STORE) && st_valid;
  assign drain     = (state == LDRAIN) && ld_valid && ld_ready;
  assign mem_wdata = st_data;

  vector_lsu_agen u_agen (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .step     (capture || st_beat),
    .base     (cmd_addr),
    .beats    (cmd_beats),
`ifdef VECTOR_LSU_STRIDE_EN
    .stride_in(cmd_stride),
`endif
    .addr     (cur_addr),
    .last     (agen_last)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake/memory strobes.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    st_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = cur_addr;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        mem_addr  = '0;
        if (cmd_valid && (cmd_beats != '0))
          state_nxt = (cmd_op == OP_STORE) ? STORE : LOAD;
      end
      LOAD: begin
        if (capture && agen_last) state_nxt = LDRAIN;
      end
      LDRAIN: begin
        if (drain) state_nxt = IDLE;
      end
      STORE: begin
        st_ready = 1'b1;
        mem_we   = st_valid;
        if (st_valid && agen_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load beat register and completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_valid <= 1'b0;
      ld_last  <= 1'b0;
      ld_data  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        ld_data  <= mem_rdata;
        ld_valid <= 1'b1;
        ld_last  <= agen_last;
      end
      if (drain) begin
        ld_valid <= 1'b0;
        ld_last  <= 1'b0;
        done     <= 1'b1;
      end
      if (accept && (cmd_beats == '0)) done <= 1'b1;
      if (st_beat && agen_last)        done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_lsu.sv
// Self-checking bench for vector_lsu with a word-addressed memory model.
module tb_vector_lsu;
  import vproc_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [BEAT_W-1:0] cmd_beats;
`ifdef VECTOR_LSU_STRIDE_EN
  logic [ADDR_W-1:0] cmd_stride;
`endif
  logic              st_valid, st_ready;
  logic [DATA_W-1:0] st_data;
  logic              ld_valid, ld_ready, ld_last;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we, busy, done;

  vector_lsu dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
`ifdef VECTOR_LSU_STRIDE_EN
    .cmd_stride(cmd_stride),
`endif
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory: 512 x 32-bit words, a beat spans 16 consecutive words with wrap.
  logic [31:0]       mem     [512];
  logic [31:0]       ref_mem [512];
  logic              tb_we;
  logic [ADDR_W-1:0] tb_waddr;
  logic [DATA_W-1:0] tb_wdata;

  always_comb begin
    for (int i = 0; i < 16; i++)
      mem_rdata[32*i +: 32] = mem[ADDR_W'(mem_addr + ADDR_W'(i))];
  end

  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 16; i++) mem[ADDR_W'(mem_addr + ADDR_W'(i))] <= mem_wdata[32*i +: 32];
    end else if (tb_we) begin
      for (int i = 0; i < 16; i++) mem[ADDR_W'(tb_waddr + ADDR_W'(i))] <= tb_wdata[32*i +: 32];
    end
  end

  int checks = 0;
  int errors = 0;

  // Driver state and observations of the most recent command.
  logic [DATA_W-1:0] st_q[$];
  logic [DATA_W-1:0] st_copy[$];
  bit                pat[$];
  int                ready_pct;
  logic [DATA_W-1:0] rx_data[$];
  bit                rx_last[$];
  int unsigned       addr_log[$];
  int unsigned       ncap_log[$];
  int                we_count, done_count, done_cycle, first_vld, last_hs, stall_changes;
  bit                timed_out, acc_ok, rdy0;

  function automatic int unsigned eff_stride(input int unsigned s);
`ifdef VECTOR_LSU_STRIDE_EN
    return s % 512;
`else
    return (s * 0) + LANES;
`endif
  endfunction

  // Expected beat b of a load: 16 consecutive words starting at addr + b*stride.
  function automatic logic [DATA_W-1:0] exp_beat(input int unsigned addr, input int unsigned b,
                                                 input int unsigned stride);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = ref_mem[(addr + b * stride + i) % 512];
    return r;
  endfunction

  task automatic ref_store(input int unsigned addr, input int unsigned stride);
    for (int b = 0; b < st_copy.size(); b++)
      for (int i = 0; i < 16; i++)
        ref_mem[(addr + b * stride + i) % 512] = st_copy[b][32*i +: 32];
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int w = 0; w < 512; w++) if (mem[w] !== ref_mem[w]) n++;
    return n;
  endfunction

  task automatic preload(input bit rnd);
    logic [31:0] v;
    for (int b = 0; b < 32; b++) begin
      @(negedge clk);
      tb_we = 1'b1;
      tb_waddr = ADDR_W'(b * 16);
      for (int i = 0; i < 16; i++) begin
        v = rnd ? $urandom : 32'(b * 16 + i);
        tb_wdata[32*i +: 32] = v;
        ref_mem[b * 16 + i] = v;
      end
    end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Issue one command and record what the DUT does; cycle 0 is the cycle after acceptance.
  task automatic exec_cmd(input logic op, input int unsigned addr, input int unsigned beats,
                          input int unsigned stride);
    logic [DATA_W-1:0] prev;
    bit                prev_stall, drv;
    int                cyc, hs;
    rx_data.delete(); rx_last.delete(); addr_log.delete(); ncap_log.delete();
    we_count = 0; done_count = 0; done_cycle = -1; first_vld = -1; last_hs = -1;
    stall_changes = 0; timed_out = 1'b0; prev_stall = 1'b0; prev = '0; hs = 0; cyc = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = ADDR_W'(addr); cmd_beats = BEAT_W'(beats);
`ifdef VECTOR_LSU_STRIDE_EN
    cmd_stride = ADDR_W'(stride);
`else
    if (stride > 9999) $display("note: stride %0d ignored", stride);
`endif
    #1 acc_ok = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
    forever begin
      if (pat.size() > 0) drv = pat.pop_front();
      else drv = ($urandom_range(99) < ready_pct);
      ld_ready = drv;
      st_valid = drv && (st_q.size() > 0);
      st_data  = (st_q.size() > 0) ? st_q[0] : '0;
      #1;
      if (cyc == 0) rdy0 = cmd_ready;
      if (prev_stall && ld_data !== prev) stall_changes++;
      if (ld_valid && first_vld < 0) first_vld = cyc;
      if (op == OP_LOAD && busy && (hs + int'(ld_valid)) < int'(beats)) begin
        addr_log.push_back(int'(mem_addr));
        ncap_log.push_back(hs + int'(ld_valid));
      end
      if (ld_valid && ld_ready) begin
        rx_data.push_back(ld_data); rx_last.push_back(ld_last); hs++; last_hs = cyc;
      end
      prev_stall = ld_valid && !ld_ready;
      prev = ld_data;
      if (mem_we) begin
        we_count++;
        if (st_q.size() > 0) void'(st_q.pop_front());
      end
      if (done) begin
        done_count++;
        if (done_cycle < 0) done_cycle = cyc;
      end
      if (done_cycle >= 0 && cyc >= done_cycle + 2) break;
      if (cyc >= 400) begin timed_out = 1'b1; break; end
      cyc++;
      @(negedge clk);
    end
    ld_ready = 1'b0; st_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL rst_st_ready got %b want 0", st_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr got %0d want 0", mem_addr); end
    checks++; if (ld_valid !== 1'b0 || ld_last !== 1'b0) begin errors++; $display("FAIL rst_ld got v=%b l=%b want 0 0", ld_valid, ld_last); end
    checks++; if (ld_data !== '0) begin errors++; $display("FAIL rst_ld_data got %h want 0", ld_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle got rdy=%b busy=%b want 1 0", cmd_ready, busy); end
  endtask

  task automatic test_load_basic();
    preload(1'b0);
    ready_pct = 100;
    exec_cmd(OP_LOAD, 0, 2, 16);
    checks++; if (acc_ok !== 1'b1) begin errors++; $display("FAIL ld_accept got %b want 1", acc_ok); end
    checks++; if (first_vld != 1) begin errors++; $display("FAIL ld_first_valid got %0d want 1", first_vld); end
    checks++; if (rx_data.size() != 2) begin errors++; $display("FAIL ld_beats got %0d want 2", rx_data.size()); end
    else begin
      for (int b = 0; b < 2; b++) begin
        checks++;
        if (rx_data[b] !== exp_beat(0, b, 16)) begin errors++; $display("FAIL ld_beat%0d got %h want %h", b, rx_data[b], exp_beat(0, b, 16)); end
      end
      checks++; if (rx_data[1][31:0] !== 32'd16 || rx_data[0][511:480] !== 32'd15) begin errors++; $display("FAIL ld_lane_values got %0d %0d want 16 15", rx_data[1][31:0], rx_data[0][511:480]); end
      checks++; if (rx_last[0] !== 1'b0 || rx_last[1] !== 1'b1) begin errors++; $display("FAIL ld_last got %b%b want 01", rx_last[0], rx_last[1]); end
    end
    checks++; if (done_cycle != last_hs + 1 || done_count != 1) begin errors++; $display("FAIL ld_done got cyc=%0d n=%0d want cyc=%0d n=1", done_cycle, done_count, last_hs + 1); end
    checks++; if (timed_out) begin errors++; $display("FAIL ld_timeout got 1 want 0"); end
  endtask

  task automatic test_store_wrap();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = 32'hA0 + 32'(i);
    st_q.delete(); st_copy.delete();
    st_q.push_back(d); st_copy.push_back(d);
    ready_pct = 100;
    exec_cmd(OP_STORE, 504, 1, 16);
    ref_store(504, 16);
    checks++; if (we_count != 1) begin errors++; $display("FAIL st_we_count got %0d want 1", we_count); end
    checks++; if (mem[504] !== 32'hA0 || mem[511] !== 32'hA7) begin errors++; $display("FAIL st_top got %h %h want a0 a7", mem[504], mem[511]); end
    checks++; if (mem[0] !== 32'hA8 || mem[7] !== 32'hAF) begin errors++; $display("FAIL st_wrap got %h %h want a8 af", mem[0], mem[7]); end
    checks++; if (mem_diffs() != 0) begin errors++; $display("FAIL st_mem got %0d bad words want 0", mem_diffs()); end
    checks++; if (done_cycle != 1 || done_count != 1) begin errors++; $display("FAIL st_done got cyc=%0d n=%0d want cyc=1 n=1", done_cycle, done_count); end
  endtask

  task automatic test_load_stall();
    pat.delete();
    pat.push_back(1'b1); pat.push_back(1'b0); pat.push_back(1'b0);
    pat.push_back(1'b1); pat.push_back(1'b1);
    ready_pct = 100;
    exec_cmd(OP_LOAD, 0, 3, 16);
    checks++; if (rx_data.size() != 3) begin errors++; $display("FAIL stall_beats got %0d want 3", rx_data.size()); end
    else begin
      for (int b = 0; b < 3; b++) begin
        checks++;
        if (rx_data[b] !== exp_beat(0, b, 16) || rx_last[b] !== (b == 2)) begin errors++; $display("FAIL stall_beat%0d got last=%b %h want %h", b, rx_last[b], rx_data[b], exp_beat(0, b, 16)); end
      end
    end
    checks++; if (stall_changes != 0) begin errors++; $display("FAIL stall_hold got %0d changes want 0", stall_changes); end
    checks++; if (addr_log.size() < 3) begin errors++; $display("FAIL stall_addr_log got %0d entries want >=3", addr_log.size()); end
    for (int k = 0; k < addr_log.size(); k++) begin
      checks++;
      if (addr_log[k] != (ncap_log[k] * 16) % 512) begin errors++; $display("FAIL stall_addr%0d got %0d want %0d", k, addr_log[k], (ncap_log[k] * 16) % 512); end
    end
    checks++; if (done_cycle != last_hs + 1) begin errors++; $display("FAIL stall_done got %0d want %0d", done_cycle, last_hs + 1); end
  endtask

  task automatic test_zero_beats();
    st_q.delete();
    st_q.push_back({16{32'hDEAD0000}});
    ready_pct = 100;
    exec_cmd(OP_STORE, 100, 0, 16);
    st_q.delete();
    checks++; if (we_count != 0) begin errors++; $display("FAIL zero_we got %0d want 0", we_count); end
    checks++; if (done_cycle != 0 || done_count != 1) begin errors++; $display("FAIL zero_done got cyc=%0d n=%0d want cyc=0 n=1", done_cycle, done_count); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", rdy0); end
    checks++; if (mem_diffs() != 0) begin errors++; $display("FAIL zero_mem got %0d bad words want 0", mem_diffs()); end
  endtask

  task automatic test_reset_mid_store();
    logic [DATA_W-1:0] d[4];
    int unsigned a;
    a = $urandom_range(511);
    for (int b = 0; b < 4; b++) for (int i = 0; i < 16; i++) d[b][32*i +: 32] = $urandom;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_STORE; cmd_addr = ADDR_W'(a); cmd_beats = BEAT_W'(4);
    @(negedge clk);
    cmd_valid = 1'b0; st_valid = 1'b1; st_data = d[0];
    @(negedge clk);
    st_data = d[1];
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL mid_we_before got %b want 1", mem_we); end
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || st_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got busy=%b rdy=%b st=%b want 0 1 0", busy, cmd_ready, st_ready); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== '0) begin errors++; $display("FAIL mid_rst_mem got we=%b addr=%0d want 0 0", mem_we, mem_addr); end
    checks++; if (ld_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_rst_out got v=%b done=%b want 0 0", ld_valid, done); end
    @(negedge clk);
    reset = 1'b0; st_valid = 1'b0;
    st_copy.delete(); st_copy.push_back(d[0]);
    ref_store(a, 16);
    checks++; if (mem_diffs() != 0) begin errors++; $display("FAIL mid_mem got %0d bad words want 0", mem_diffs()); end
    ready_pct = 100;
    exec_cmd(OP_LOAD, a, 1, 16);
    checks++; if (acc_ok !== 1'b1 || done_count != 1) begin errors++; $display("FAIL mid_new_cmd got acc=%b done=%0d want 1 1", acc_ok, done_count); end
    checks++; if (rx_data.size() != 1 || rx_data[0] !== d[0]) begin errors++; $display("FAIL mid_readback got n=%0d want 1 beat %h", rx_data.size(), d[0]); end
  endtask

  task automatic test_stride();
    int unsigned s;
    preload(1'b0);
    s = eff_stride(0);
    ready_pct = 100;
    exec_cmd(OP_LOAD, 5, 3, 0);
    checks++; if (rx_data.size() != 3) begin errors++; $display("FAIL stride_beats got %0d want 3", rx_data.size()); end
    else begin
      for (int b = 0; b < 3; b++) begin
        checks++;
        if (rx_data[b][31:0] !== 32'(5 + b * s)) begin errors++; $display("FAIL stride_lane0_%0d got %0d want %0d", b, rx_data[b][31:0], 5 + b * s); end
        checks++;
        if (rx_data[b] !== exp_beat(5, b, s)) begin errors++; $display("FAIL stride_beat%0d got %h want %h", b, rx_data[b], exp_beat(5, b, s)); end
      end
    end
  endtask

  task automatic test_random();
    logic              op;
    int unsigned       a, n, s, es;
    logic [DATA_W-1:0] d;
    preload(1'b1);
    for (int it = 0; it < 24; it++) begin
      op = 1'($urandom_range(1));
      a  = $urandom_range(511);
      n  = ($urandom_range(7) == 0) ? 32 : $urandom_range(6);
      s  = $urandom_range(40);
      es = eff_stride(s);
      ready_pct = $urandom_range(30, 100);
      st_q.delete(); st_copy.delete();
      if (op == OP_STORE) begin
        for (int b = 0; b < int'(n); b++) begin
          for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
          st_q.push_back(d); st_copy.push_back(d);
        end
      end
      exec_cmd(op, a, n, s);
      checks++; if (timed_out || done_count != 1) begin errors++; $display("FAIL rnd%0d_done got to=%b n=%0d want 0 1", it, timed_out, done_count); end
      if (op == OP_STORE) begin
        ref_store(a, es);
        checks++; if (we_count != int'(n)) begin errors++; $display("FAIL rnd%0d_we got %0d want %0d", it, we_count, n); end
        checks++; if (mem_diffs() != 0) begin errors++; $display("FAIL rnd%0d_mem got %0d bad words want 0", it, mem_diffs()); end
      end else begin
        checks++; if (rx_data.size() != n) begin errors++; $display("FAIL rnd%0d_beats got %0d want %0d", it, rx_data.size(), n); end
        for (int b = 0; b < rx_data.size() && b < int'(n); b++) begin
          checks++;
          if (rx_data[b] !== exp_beat(a, b, es) || rx_last[b] !== (b == int'(n) - 1)) begin errors++; $display("FAIL rnd%0d_beat%0d got last=%b %h want %h", it, b, rx_last[b], rx_data[b], exp_beat(a, b, es)); end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_beats = '0;
`ifdef VECTOR_LSU_STRIDE_EN
    cmd_stride = '0;
`endif
    st_valid = 1'b0; st_data = '0; ld_ready = 1'b0;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0; ready_pct = 100; rdy0 = 1'b0;
    test_reset();
    test_load_basic();
    test_store_wrap();
    test_load_stall();
    test_zero_beats();
    test_reset_mid_store();
    test_stride();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
